dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the 128x32 word data memory.
//  Shares the memory between requester 0 (core load/store unit) and requester 1 (DMA/program loader).
//  Drives the memory's read strobe, write strobe, 9-bit byte address and write data.
//  Returns read data or write completion per requester, and rejects misaligned addresses without touching memory.
// PARAMETERS
//  ADDR_W  9   byte address width; word index = addr[ADDR_W-1:2]
//  DATA_W  32  data width
// PORTS
//  clk         in   1       rising-edge clock, single clock domain
//  rst_n       in   1       asynchronous active-low reset
//  req0/req1   in   1       access request; held with its fields until gnt
//  we0/we1     in   1       1=write, 0=read
//  addr0/addr1 in   ADDR_W  byte address
//  wdata0/1    in   DATA_W  write data
//  gnt0/gnt1   out  1       1-cycle pulse: request accepted, fields latched
//  done0/done1 out  1       1-cycle pulse: access finished (read data valid / write committed)
//  err0/err1   out  1       valid with done; 1 = misaligned (addr[1:0]!=0), no memory access made
//  rdata0/1    out  DATA_W  read data; valid with done on a read, holds last value otherwise
//  mem_read    out  1       memory read strobe
//  mem_write   out  1       memory write strobe
//  mem_addr    out  ADDR_W  memory byte address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, combinational, valid during mem_read
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, rr_ptr=0 (req0 favoured); all outputs 0, including the mem_* outputs and rdata0/1.
//    An in-flight access is dropped with no done, and the memory strobes drop immediately.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; registered outputs; one transaction in flight.
//  - IDLE: if any req, choose the winner.
//    - Only one request: that requester wins.
//    - Both request: the requester pointed to by rr_ptr wins.
//    - Latch we/addr/wdata/id, pulse gnt_id, set rr_ptr=~id, go to ACCESS. No req: stay in IDLE.
//  - ACCESS (exactly 1 cycle):
//    - Aligned: mem_read=~we or mem_write=we (never both), with mem_addr/mem_wdata from the latch.
//    - Read: capture mem_rdata at the end of the cycle.
//    - Misaligned: no strobe; set the error flag.
//  - RESP: pulse done_id (plus err_id if misaligned); on a read, rdata_id <= captured data. Then go to IDLE.
//    The other requester's rdata is unchanged.
//  - Latency: req seen in IDLE at edge N -> gnt at N+1, strobe during cycle N+1..N+2, done at N+3.
//    Peak throughput is 1 access per 3 cycles.
//  - mem_addr/mem_wdata hold their last value outside ACCESS; strobes are 0 outside ACCESS.
//  - A req that stays high after gnt is treated as a new request at the next IDLE.
//  - Requests arriving during ACCESS/RESP are not sampled until IDLE.
//  - Fairness: with both reqs held continuously, grants alternate 0,1,0,1...
//    No requester waits more than one other transaction.
//  - Widths: no arithmetic. Word index = mem_addr[ADDR_W-1:2], computed by the memory.
// STRUCTURE
//  - Shared package dmem_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2),
//    requester id constants REQ_CORE=1'b0, REQ_DMA=1'b1.
//  - One sub-module, dmem_rr_arb: combinational 2-way round-robin pick (req0, req1, rr_ptr -> valid, id).
//  - FSM, latches and output registers live in dmem_arbiter. Connect to the data memory with a behavioural model in the bench.
// TESTING
//  1. Reset: assert rst_n=0 mid-ACCESS -> mem_read/mem_write/gnt/done drop at once; after release the first grant goes to req0.
//  2. Single write then read: req0 we=1 addr=0x010 wdata=0xDEADBEEF.
//     -> mem_write for 1 cycle, addr 0x010, done0 at +3.
//     Then req0 read 0x010 -> done0 with rdata0=0xDEADBEEF.
//  3. Contention: req0 and req1 held high, reads of 0x000/0x004 -> gnt order 0,1,0,1; each done follows its gnt by 2 cycles.
//  4. Misaligned: req1 read addr=0x013 -> no mem_read/mem_write strobe; done1=err1=1; rdata1 unchanged.
//  5. Isolation: req1 write 0x1FC=0x12345678, then req0 read 0x1FC -> rdata0=0x12345678; rdata1 keeps its prior value.
//  6. Protocol checks throughout: mem_read&mem_write never both 1; gnt0&gnt1 never both 1; at most one transaction outstanding.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  // Request payload of the winning requester, latched at grant
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
  parameter int unsigned DATA_W = dmem_pkg::DATA_W
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  // Requesters plus memory
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_rr_arb.sv
// Combinational 2-way round-robin pick; rr_ptr breaks ties only.
module dmem_rr_arb (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_ptr_i,
  output logic valid_o_c,
  output logic id_o_c
);

  assign valid_o_c = req0_i | req1_i;
  assign id_o_c    = (req0_i & req1_i) ? rr_ptr_i : req1_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing the word data memory between core and DMA.
module dmem_arbiter
  import dmem_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                pick_valid_c;
  logic                pick_id_c;
  req_t                win_c;
  logic                win_aligned_c;

  dmem_rr_arb u_rr_arb (
    .req0_i    (bus.req0),
    .req1_i    (bus.req1),
    .rr_ptr_i  (rr_q),
    .valid_o_c (pick_valid_c),
    .id_o_c    (pick_id_c)
  );

  // Payload of whichever requester the picker selected
  always_comb begin
    win_c = '0;
    if (pick_id_c == REQ_DMA) begin
      win_c.we    = bus.we1;
      win_c.addr  = bus.addr1;
      win_c.wdata = bus.wdata1;
    end else begin
      win_c.we    = bus.we0;
      win_c.addr  = bus.addr0;
      win_c.wdata = bus.wdata0;
    end
    win_aligned_c = is_aligned(win_c.addr[1:0]);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    we_d        = we_q;
    mis_d       = mis_q;
    cap_d       = cap_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          id_d    = pick_id_c;
          we_d    = win_c.we;
          mis_d   = ~win_aligned_c;
          rr_d    = ~pick_id_c;
          gnt0_d  = (pick_id_c == REQ_CORE);
          gnt1_d  = (pick_id_c == REQ_DMA);
          // Strobes are registered here so they are live for the whole ACCESS cycle
          if (win_aligned_c) begin
            mem_read_d  = ~win_c.we;
            mem_write_d = win_c.we;
            mem_addr_d  = win_c.addr;
            mem_wdata_d = win_c.wdata;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_read_q) begin
          cap_d = bus.mem_rdata;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (id_q == REQ_DMA) begin
          done1_d = 1'b1;
          err1_d  = mis_q;
          if (!we_q && !mis_q) begin
            rdata1_d = cap_q;
          end
        end else begin
          done0_d = 1'b1;
          err0_d  = mis_q;
          if (!we_q && !mis_q) begin
            rdata0_d = cap_q;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= REQ_CORE;
      id_q        <= REQ_CORE;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      cap_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      cap_q       <= cap_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
